// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction fetch with request/ack memory handshake, redirect
//            drop tracking, one-entry skid buffer and the IF/ID register.
// Revision : 1.0
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IC_WIDTH = 32
) (
    input  logic                Clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    input  logic                stall,
    input  logic                flush,
    output logic [IC_WIDTH-1:0] oIC,
    output logic [32:0]         oPPCCB,
    output logic [31:0]         oPC,
    output logic                oValid,
    output logic [31:0]         oIR
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_DROP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [IC_WIDTH-1:0] C_IC_ONE = IC_WIDTH'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [31:0]         r_fetch_pc;
    logic [31:0]         r_pend_pc;
    logic [31:0]         r_skid_pc;
    logic [31:0]         r_skid_ir;
    logic [IC_WIDTH-1:0] r_ic_cnt;
    logic [IC_WIDTH-1:0] r_ic;
    logic [32:0]         r_ppccb;
    logic [31:0]         r_pc;
    logic                r_valid;
    logic [31:0]         r_ir;
    logic                w_deliver;
    logic [31:0]         w_del_pc;
    logic [31:0]         w_del_ir;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_REQ: begin
                if (imem_ack) begin
                    if (!redirect && stall) begin
                        w_next_state = S_HOLD;
                    end
                end else if (redirect) begin
                    w_next_state = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    w_next_state = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_REQ;
        endcase
    end

    // Request is gated by reset so nothing is issued while reset is held.
    always_comb begin
        imem_req  = !reset && ((r_state == S_REQ) || (r_state == S_DROP));
        imem_addr = r_fetch_pc;
        w_deliver = 1'b0;
        w_del_pc  = r_fetch_pc;
        w_del_ir  = imem_rdata;
        if (r_state == S_REQ) begin
            w_deliver = imem_ack && !redirect && !stall;
        end else if (r_state == S_HOLD) begin
            w_deliver = !redirect && !stall;
            w_del_pc  = r_skid_pc;
            w_del_ir  = r_skid_ir;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_skid_pc  <= '0;
            r_skid_ir  <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            r_fetch_pc <= redirect_pc;
                        end else begin
                            r_fetch_pc <= r_fetch_pc + 32'd4;
                            if (stall) begin
                                r_skid_pc <= r_fetch_pc;
                                r_skid_ir <= imem_rdata;
                            end
                        end
                    end else if (redirect) begin
                        r_pend_pc <= redirect_pc;
                    end
                end
                S_DROP: begin
                    // The newest redirect wins, even when it coincides with the ack.
                    if (redirect) begin
                        r_pend_pc <= redirect_pc;
                    end
                    if (imem_ack) begin
                        r_fetch_pc <= redirect ? redirect_pc : r_pend_pc;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (reset || flush) begin
            r_valid <= 1'b0;
            r_ir    <= '0;
            r_pc    <= '0;
            r_ppccb <= '0;
            r_ic    <= '0;
            if (reset) begin
                r_ic_cnt <= '0;
            end
        end else if (!stall) begin
            if (w_deliver) begin
                r_valid  <= 1'b1;
                r_ir     <= w_del_ir;
                r_pc     <= w_del_pc;
                r_ppccb  <= {1'b0, w_del_pc + 32'd4};
                r_ic     <= r_ic_cnt;
                r_ic_cnt <= r_ic_cnt + C_IC_ONE;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign oValid = r_valid;
    assign oIR    = r_ir;
    assign oPC    = r_pc;
    assign oPPCCB = r_ppccb;
    assign oIC    = r_ic;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Randomized bench for if_fetch_unit with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_XOR      = 32'hA5A5_0000;

    logic        Clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        flush;
    logic [31:0] oIC;
    logic [32:0] oPPCCB;
    logic [31:0] oPC;
    logic        oValid;
    logic [31:0] oIR;

    if_fetch_unit #(
        .RESET_PC (C_RESET_PC),
        .IC_WIDTH (32)
    ) u_dut (
        .Clk         (Clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .flush       (flush),
        .oIC         (oIC),
        .oPPCCB      (oPPCCB),
        .oPC         (oPC),
        .oValid      (oValid),
        .oIR         (oIR)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference: the current memory transaction, whether a redirect has
    // poisoned it, the parked word, and the expected IF/ID contents.
    logic [31:0] m_addr;
    logic        m_tainted;
    logic [31:0] m_target;
    logic        m_skid;
    logic [31:0] m_skid_addr;
    logic [31:0] m_ic;
    logic        m_just_reset;
    logic        e_valid;
    logic [31:0] e_ir;
    logic [31:0] e_pc;
    logic [32:0] e_ppccb;
    logic [31:0] e_ic;

    int unsigned lat_min, lat_max, p_stall, p_redir, p_flush, p_spur, p_reset;
    int unsigned wait_cnt, lat_cur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr       = C_RESET_PC;
        m_tainted    = 1'b0;
        m_target     = '0;
        m_skid       = 1'b0;
        m_skid_addr  = '0;
        m_ic         = '0;
        m_just_reset = 1'b1;
        e_valid      = 1'b0;
        e_ir         = '0;
        e_pc         = '0;
        e_ppccb      = '0;
        e_ic         = '0;
    endtask

    // Applies the effect of the coming clock edge given the driven inputs.
    task automatic model_edge();
        logic        have;
        logic [31:0] a;
        have = 1'b0;
        a    = '0;
        if (reset) begin
            model_reset();
            return;
        end
        m_just_reset = 1'b0;
        if (m_skid) begin
            if (redirect) begin
                m_skid = 1'b0;
                m_addr = redirect_pc;
            end else if (!stall) begin
                have   = 1'b1;
                a      = m_skid_addr;
                m_skid = 1'b0;
            end
        end else if (imem_ack) begin
            if (redirect) begin
                m_addr    = redirect_pc;
                m_tainted = 1'b0;
            end else if (m_tainted) begin
                m_addr    = m_target;
                m_tainted = 1'b0;
            end else begin
                a      = m_addr;
                m_addr = m_addr + 32'd4;
                if (stall) begin
                    m_skid      = 1'b1;
                    m_skid_addr = a;
                end else begin
                    have = 1'b1;
                end
            end
        end else if (redirect) begin
            m_tainted = 1'b1;
            m_target  = redirect_pc;
        end
        if (flush) begin
            e_valid = 1'b0;
            e_ir    = '0;
            e_pc    = '0;
            e_ppccb = '0;
            e_ic    = '0;
        end else if (!stall) begin
            if (have) begin
                e_valid = 1'b1;
                e_ir    = a ^ C_XOR;
                e_pc    = a;
                e_ppccb = {1'b0, a + 32'd4};
                e_ic    = m_ic;
                m_ic    = m_ic + 32'd1;
            end else begin
                e_valid = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic seen_req;
        logic exp_req;
        @(negedge Clk);
        exp_req = !reset && !m_skid;
        chk("oValid", 64'(oValid), 64'(e_valid));
        chk("oIR", 64'(oIR), 64'(e_ir));
        chk("oPC", 64'(oPC), 64'(e_pc));
        chk("oPPCCB", 64'(oPPCCB), 64'(e_ppccb));
        chk("oIC", 64'(oIC), 64'(e_ic));
        chk("imem_req", 64'(imem_req), 64'(exp_req));
        if (exp_req || m_just_reset) begin
            chk("imem_addr", 64'(imem_addr), 64'(m_addr));
        end
        seen_req = imem_req;
        reset    = ($urandom_range(0, 99) < p_reset);
        stall    = ($urandom_range(0, 99) < p_stall);
        flush    = ($urandom_range(0, 99) < p_flush);
        redirect = ($urandom_range(0, 99) < p_redir);
        redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
        if (seen_req) begin
            imem_ack = (wait_cnt >= lat_cur);
        end else begin
            imem_ack = ($urandom_range(0, 99) < p_spur);
        end
        imem_rdata = imem_ack ? (imem_addr ^ C_XOR) : $urandom;
        if (seen_req && imem_ack) begin
            wait_cnt = 0;
            lat_cur  = $urandom_range(lat_min, lat_max);
        end else if (seen_req) begin
            wait_cnt++;
        end
        model_edge();
    endtask

    task automatic set_knobs(input int unsigned lmin, input int unsigned lmax,
                             input int unsigned ps, input int unsigned pr,
                             input int unsigned pf, input int unsigned pp,
                             input int unsigned prs);
        lat_min = lmin;
        lat_max = lmax;
        p_stall = ps;
        p_redir = pr;
        p_flush = pf;
        p_spur  = pp;
        p_reset = prs;
        lat_cur = $urandom_range(lmin, lmax);
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        flush       = 1'b0;
        wait_cnt    = 0;
        model_reset();
        repeat (2) @(posedge Clk);

        // Zero-wait streaming: one instruction per cycle.
        set_knobs(0, 0, 0, 0, 0, 0, 0);
        repeat (20) step();
        // Fixed three-cycle memory latency.
        set_knobs(3, 3, 0, 0, 0, 0, 0);
        repeat (24) step();
        // Redirects against short outstanding requests.
        set_knobs(0, 2, 0, 20, 0, 0, 0);
        repeat (40) step();
        // Heavy stall to exercise the skid buffer.
        set_knobs(0, 1, 60, 5, 0, 10, 0);
        repeat (40) step();
        // Everything at once, including flush, stray acks and mid-flight reset.
        set_knobs(0, 3, 30, 12, 10, 20, 3);
        repeat (600) step();
        // Final settle: release all controls and resume clean streaming.
        set_knobs(0, 0, 0, 0, 0, 0, 0);
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
